sysbus_line_xfer: RTL and testbench

//  Parametrised Sysbus line-transfer master: moves one cache line (BEATS x BUS_DATA_WIDTH) per request.

---
 rtl/sysbus_line_xfer.sv | 159 +++++++++++++++
 tb/tb_sysbus_line_xfer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_line_xfer.sv
// sysbus_line_xfer: moves one cache line of BEATS bus words per request.
// A read sends one address beat, then collects BEATS tagged responses.
// A write sends one address beat followed by BEATS data beats.
// Responses whose tag ID differs from REQ_ID belong to other masters and are left unacknowledged.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_line_xfer #(
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter int         BEATS          = 8,
  parameter logic [7:0] REQ_ID         = 8'h00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [63:0]                     req_addr,
  input  logic [BEATS*BUS_DATA_WIDTH-1:0] req_wdata,
  output logic                            busy,
  output logic                            done,
  output logic [BEATS*BUS_DATA_WIDTH-1:0] rdata,
  output logic                            bus_reqcyc,
  input  logic                            bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]       bus_req,
  output logic [BUS_TAG_WIDTH-1:0]        bus_reqtag,
  input  logic                            bus_respcyc,
  output logic                            bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]       bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]        bus_resptag
);

  localparam int W         = BUS_DATA_WIDTH;
  localparam int LINE_W    = BEATS * W;
  localparam int OFF_BITS  = $clog2(LINE_W / 8);
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [63:0] LINE_MASK = ~((64'd1 << OFF_BITS) - 64'd1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               r_state;
  logic [BEAT_BITS-1:0]     r_beat;
  logic [63:0]              r_addr;
  logic                     r_write;
  logic [LINE_W-1:0]        r_wdata;
  logic [LINE_W-1:0]        r_rdata;

  logic                     w_respHit;
  logic                     w_lastBeat;
  logic [BUS_TAG_WIDTH-1:0] w_opTag;
  logic [BUS_TAG_WIDTH-1:0] w_tag;
  logic [W-1:0]             w_req;
  logic                     w_unusedTagBits;

  assign w_opTag    = BUS_TAG_WIDTH'({(r_write ? `SYSBUS_WRITE : `SYSBUS_READ), `SYSBUS_MEMORY, REQ_ID});
  assign w_respHit  = (r_state == S_RESP) && bus_respcyc && (bus_resptag[7:0] == REQ_ID);
  assign w_lastBeat = (r_beat == LAST_BEAT);

  // Only the ID byte of a response tag decides ownership; the upper tag bits are don't-care.
  assign w_unusedTagBits = ^bus_resptag;

  assign req_ready   = (r_state == S_IDLE) && !reset;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign bus_reqcyc  = (r_state == S_ADDR) || (r_state == S_WDATA);
  assign bus_respack = w_respHit;
  assign bus_req     = w_req;
  assign bus_reqtag  = w_tag;

  // Request beat payload: line address in ADDR, current write beat in WDATA, zero otherwise.
  always_comb begin
    w_req = '0;
    w_tag = '0;
    case (r_state)
      S_ADDR: begin
        w_req = W'(r_addr);
        w_tag = w_opTag;
      end
      S_WDATA: begin
        w_req = r_wdata[int'(r_beat)*W +: W];
        w_tag = w_opTag;
      end
      default: begin
        w_req = '0;
        w_tag = '0;
      end
    endcase
  end

  // Transaction sequencer: latches the request, walks the beats, and stores read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr & LINE_MASK;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_reqack) begin
            r_beat  <= '0;
            r_state <= r_write ? S_WDATA : S_RESP;
          end
        end
        S_WDATA: begin
          if (bus_reqack) begin
            if (w_lastBeat) begin
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + BEAT_BITS'(1);
            end
          end
        end
        S_RESP: begin
          if (w_respHit) begin
            r_rdata[int'(r_beat)*W +: W] <= bus_resp;
            if (w_lastBeat) begin
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + BEAT_BITS'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_line_xfer.sv
// tb_sysbus_line_xfer: drives an 8-beat and a 1-beat instance from shared stimulus
// and compares them against a line-level model of the transfer (addresses, beat
// order, collected data, completion cycle).

module tb_sysbus_line_xfer;

  logic         clk = 1'b0;
  logic         reset;
  logic         reqValid;
  logic         reqWrite;
  logic [63:0]  reqAddr;
  logic [511:0] reqWdata;
  logic         busReqack;
  logic         busRespcyc;
  logic [63:0]  busResp;
  logic [12:0]  busResptag;

  logic         lReady, lBusy, lDone, lReqcyc, lRespack;
  logic [511:0] lRdata;
  logic [63:0]  lReq;
  logic [12:0]  lReqtag;

  logic         sReady, sBusy, sDone, sReqcyc, sRespack;
  logic [63:0]  sRdata;
  logic [63:0]  sReq;
  logic [12:0]  sReqtag;

  logic         useSingle;
  logic         obsReady, obsBusy, obsDone, obsReqcyc, obsRespack;
  logic [511:0] obsRdata;
  logic [63:0]  obsReq;
  logic [12:0]  obsReqtag;

  logic [511:0] modelRdata;
  int           cyc = 0;
  int           nAssert = 0;
  int           nFail = 0;

  always #5 clk = ~clk;

  // Cycle index: at the falling edge after k rising edges this reads k.
  always @(posedge clk) cyc <= cyc + 1;

  sysbus_line_xfer #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(8), .REQ_ID(8'h00)
  ) dutLine (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(lReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .busy(lBusy), .done(lDone), .rdata(lRdata),
    .bus_reqcyc(lReqcyc), .bus_reqack(busReqack), .bus_req(lReq), .bus_reqtag(lReqtag),
    .bus_respcyc(busRespcyc), .bus_respack(lRespack), .bus_resp(busResp), .bus_resptag(busResptag)
  );

  sysbus_line_xfer #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(1), .REQ_ID(8'h3C)
  ) dutSingle (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(sReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata[63:0]),
    .busy(sBusy), .done(sDone), .rdata(sRdata),
    .bus_reqcyc(sReqcyc), .bus_reqack(busReqack), .bus_req(sReq), .bus_reqtag(sReqtag),
    .bus_respcyc(busRespcyc), .bus_respack(sRespack), .bus_resp(busResp), .bus_resptag(busResptag)
  );

  // Route the outputs of whichever instance is under test to a common view.
  always_comb begin
    obsReady   = useSingle ? sReady   : lReady;
    obsBusy    = useSingle ? sBusy    : lBusy;
    obsDone    = useSingle ? sDone    : lDone;
    obsReqcyc  = useSingle ? sReqcyc  : lReqcyc;
    obsRespack = useSingle ? sRespack : lRespack;
    obsReq     = useSingle ? sReq     : lReq;
    obsReqtag  = useSingle ? sReqtag  : lReqtag;
    obsRdata   = useSingle ? {448'd0, sRdata} : lRdata;
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 512'(obs), 512'(exp));
  endtask

  task automatic idleInputs();
    reqValid   = 1'b0;
    reqWrite   = 1'b0;
    busReqack  = 1'b0;
    busRespcyc = 1'b0;
    busResp    = {$urandom, $urandom};
    busResptag = 13'($urandom);
  endtask

  // One-cycle reset pulse; rdata is expected back at zero afterwards.
  task automatic resetPulse();
    idleInputs();
    reset = 1'b1;
    #1;
    checkBit("ready_in_reset", obsReady, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    modelRdata = '0;
    #1;
    checkBit("post_reset_busy", obsBusy, 1'b0);
    checkOutput("post_reset_rdata", obsRdata, modelRdata);
    @(negedge clk);
  endtask

  // One full line transaction. dataMode: 0 random, 1 beat i = i, 2 beat i = 0xA0+i.
  task automatic applyStimulus(input bit isWrite, input logic [63:0] addr, input int addrStall,
                               input int gapPct, input bit injectForeign, input int dataMode);
    int           nBeats;
    int           tStart;
    int           extra;
    int           gaps;
    logic [7:0]   id;
    logic [63:0]  lineAddr;
    logic [12:0]  expTag;
    logic [63:0]  beatData [8];
    logic [511:0] line;
    nBeats   = useSingle ? 1 : 8;
    id       = useSingle ? 8'h3C : 8'h00;
    lineAddr = addr & ~(64'(nBeats * 8) - 64'd1);
    expTag   = {(isWrite ? 1'b0 : 1'b1), 4'b0001, id};
    line     = '0;
    extra    = 0;
    for (int i = 0; i < 8; i++) begin
      if (dataMode == 1)      beatData[i] = 64'(i);
      else if (dataMode == 2) beatData[i] = 64'(8'hA0 + i);
      else                    beatData[i] = {$urandom, $urandom};
      if (i < nBeats) line[i*64 +: 64] = beatData[i];
    end

    reqValid = 1'b1;
    reqWrite = isWrite;
    reqAddr  = addr;
    reqWdata = isWrite ? line : {16{$urandom}};
    #1;
    checkBit("req_ready", obsReady, 1'b1);
    tStart = cyc;
    @(negedge clk);
    reqValid = 1'b0;
    reqAddr  = {$urandom, $urandom};
    reqWdata = {16{$urandom}};

    for (int s = 0; s <= addrStall; s++) begin
      busReqack = (s == addrStall);
      #1;
      checkBit("addr_reqcyc", obsReqcyc, 1'b1);
      checkOutput("addr_req", 512'(obsReq), 512'(lineAddr));
      checkOutput("addr_tag", 512'(obsReqtag), 512'(expTag));
      @(negedge clk);
    end
    busReqack = 1'b0;

    if (isWrite) begin
      for (int i = 0; i < nBeats; i++) begin
        gaps = 0;
        while (gaps < 3 && $urandom_range(99) < gapPct) begin
          busReqack = 1'b0;
          #1;
          checkOutput("wdata_held", 512'(obsReq), 512'(beatData[i]));
          extra++;
          gaps++;
          @(negedge clk);
        end
        busReqack = 1'b1;
        #1;
        checkBit("wdata_reqcyc", obsReqcyc, 1'b1);
        checkOutput("wdata_beat", 512'(obsReq), 512'(beatData[i]));
        checkOutput("wdata_tag", 512'(obsReqtag), 512'(expTag));
        checkBit("wdata_no_done", obsDone, 1'b0);
        @(negedge clk);
      end
      busReqack = 1'b0;
    end else begin
      for (int i = 0; i < nBeats; i++) begin
        gaps = 0;
        while (gaps < 3 && $urandom_range(99) < gapPct) begin
          busRespcyc = 1'b0;
          #1;
          checkBit("gap_respack", obsRespack, 1'b0);
          extra++;
          gaps++;
          @(negedge clk);
        end
        if (injectForeign && i == nBeats / 2) begin
          busRespcyc = 1'b1;
          busResptag = {5'($urandom), 8'h05};
          busResp    = 64'hDEAD;
          #1;
          checkBit("foreign_respack", obsRespack, 1'b0);
          extra++;
          @(negedge clk);
        end
        busRespcyc = 1'b1;
        busResptag = {5'($urandom), id};
        busResp    = beatData[i];
        #1;
        checkBit("resp_respack", obsRespack, 1'b1);
        checkBit("resp_reqcyc", obsReqcyc, 1'b0);
        checkBit("resp_no_done", obsDone, 1'b0);
        @(negedge clk);
      end
      busRespcyc = 1'b0;
      modelRdata = line;
    end

    #1;
    checkBit("done_pulse", obsDone, 1'b1);
    checkOutput("done_cycle", 512'(cyc), 512'(tStart + 2 + addrStall + nBeats + extra));
    checkOutput("rdata", obsRdata, modelRdata);
    reqValid = 1'b1;
    reqAddr  = {$urandom, $urandom};
    @(negedge clk);
    reqValid = 1'b0;
    #1;
    checkBit("done_once", obsDone, 1'b0);
    checkBit("back_idle", obsBusy, 1'b0);
    checkBit("idle_ready", obsReady, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    useSingle  = 1'b0;
    modelRdata = '0;
    reqAddr    = '0;
    reqWdata   = '0;
    idleInputs();
    reset    = 1'b1;
    reqValid = 1'b1;
    @(negedge clk);
    #1;
    checkBit("rst_ready", obsReady, 1'b0);
    checkBit("rst_busy", obsBusy, 1'b0);
    checkBit("rst_done", obsDone, 1'b0);
    checkBit("rst_reqcyc", obsReqcyc, 1'b0);
    checkBit("rst_respack", obsRespack, 1'b0);
    checkOutput("rst_req", 512'(obsReq), 512'd0);
    checkOutput("rst_reqtag", 512'(obsReqtag), 512'd0);
    checkOutput("rst_rdata", obsRdata, 512'd0);
    // Last reset-high cycle with a request pending: it must not be taken.
    @(negedge clk);
    reset    = 1'b0;
    reqValid = 1'b0;
    #1;
    checkBit("req_during_reset_ignored", obsBusy, 1'b0);
    @(negedge clk);

    $display("[TB] directed reads and writes, 8-beat line");
    applyStimulus(1'b0, 64'h1000_0038, 0, 0, 1'b0, 1);
    applyStimulus(1'b0, 64'h0000_0000_3456_7891, 3, 0, 1'b0, 0);
    applyStimulus(1'b0, 64'h0000_00AB_CDEF_0040, 1, 40, 1'b1, 0);
    applyStimulus(1'b1, 64'h2000_0000, 0, 30, 1'b0, 2);

    $display("[TB] random transactions");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'($urandom), {$urandom, $urandom}, int'($urandom_range(3)),
                    int'($urandom_range(50)), 1'($urandom), 0);
    end

    $display("[TB] reset in the middle of a read");
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = 64'h0000_0000_5000_0000;
    @(negedge clk);
    reqValid  = 1'b0;
    busReqack = 1'b1;
    @(negedge clk);
    busReqack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busRespcyc = 1'b1;
      busResptag = 13'h1000;
      busResp    = {$urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    modelRdata = '0;
    for (int i = 3; i < 8; i++) begin
      busRespcyc = 1'b1;
      busResptag = 13'h1000;
      busResp    = {$urandom, $urandom};
      #1;
      checkBit("midrst_respack", obsRespack, 1'b0);
      checkBit("midrst_reqcyc", obsReqcyc, 1'b0);
      checkBit("midrst_busy", obsBusy, 1'b0);
      @(negedge clk);
    end
    busRespcyc = 1'b0;
    #1;
    checkOutput("midrst_rdata", obsRdata, modelRdata);
    @(negedge clk);
    applyStimulus(1'b0, 64'h0000_0000_5000_0010, 0, 20, 1'b0, 0);

    $display("[TB] single-beat instance");
    useSingle = 1'b1;
    resetPulse();
    applyStimulus(1'b0, 64'h0000_0000_7000_000F, 0, 0, 1'b0, 0);
    applyStimulus(1'b1, 64'h0000_0000_7000_0104, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 64'h0000_0000_7100_0008, 2, 50, 1'b1, 0);
    applyStimulus(1'b1, 64'h0000_0000_7200_0003, 1, 50, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
